// File: rtl/conv_unit_scheduler_pkg.sv
// Shared definitions for the convolution-unit scheduler: FSM state
// encodings and an index-width helper reused by the conv controllers.
package conv_unit_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } sched_state_t;

    // Bits needed to index 'value' entries, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = $clog2(value);
        if (width < 1) begin
            width = 1;
        end else begin
            width = width;
        end
        return width;
    endfunction

endpackage

// File: rtl/conv_unit_scheduler_if.sv
// Result stream of the scheduler: valid/ready handshake carrying the
// captured unit result together with its output-grid position tag.
interface conv_unit_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RW         = 4,
    parameter int CW         = 4
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [RW-1:0]         out_row;
    logic [CW-1:0]         out_col;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        output out_ready
    );
endinterface

// File: rtl/conv_pos_counter.sv
// Raster-order position counter over an OH x OW output grid. clr returns
// to (0,0); adv steps one column, wrapping to the next row at the last column.
module conv_pos_counter #(
    parameter int OH = 14,
    parameter int OW = 14,
    parameter int RW = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);
    localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);

    // Position register: clear has priority over advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= {RW{1'b0}};
            col <= {CW{1'b0}};
        end else if (clr) begin
            row <= {RW{1'b0}};
            col <= {CW{1'b0}};
        end else if (adv) begin
            if (col == COL_LAST) begin
                col <= {CW{1'b0}};
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end else begin
            row <= row;
            col <= col;
        end
    end

    assign last = (row == ROW_LAST) && (col == COL_LAST);
endmodule

// File: rtl/conv_unit_scheduler.sv
// Sequences one convolution unit over every valid stride-1 window of an
// HxW image in raster order: present window, restart unit, wait its fixed
// latency, capture the result and hand it out on a valid/ready stream.
module conv_unit_scheduler
    import conv_unit_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int D          = 2,
    parameter int F          = 3,
    parameter int H          = 16,
    parameter int W          = 16,
    parameter int LATENCY    = 20,
    parameter int RW         = clog2_min1(H),
    parameter int CW         = clog2_min1(W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [RW-1:0]         win_row,
    output logic [CW-1:0]         win_col,
    output logic                  unit_reset,
    input  logic [DATA_WIDTH-1:0] unit_result,
    conv_unit_scheduler_if.master out_if
);
    localparam int OH    = H - F + 1;
    localparam int OW    = W - F + 1;
    localparam int CNT_W = clog2_min1(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    // An illegal geometry never leaves IDLE, so the unit stays held in reset.
    localparam bit CFG_OK = (D >= 1) && (F >= 1) && (F <= H) && (F <= W) && (LATENCY >= 1);

    sched_state_t          state_r;
    sched_state_t          next_state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic                  pos_clr_s;
    logic                  pos_adv_s;
    logic                  pos_last_s;
    logic                  capture_s;
    logic                  busy_r;
    logic                  done_r;
    logic                  unit_reset_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [RW-1:0]         out_row_r;
    logic [CW-1:0]         out_col_r;

    conv_pos_counter #(
        .OH (OH),
        .OW (OW),
        .RW (RW),
        .CW (CW)
    ) u_pos (
        .clk   (clk),
        .reset (reset),
        .clr   (pos_clr_s),
        .adv   (pos_adv_s),
        .row   (win_row),
        .col   (win_col),
        .last  (pos_last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode plus window-counter and capture strobes.
    always_comb begin
        next_state_s = state_r;
        pos_clr_s    = 1'b0;
        pos_adv_s    = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && CFG_OK) begin
                    next_state_s = ST_LOAD;
                    pos_clr_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                next_state_s = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = ST_EMIT;
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_EMIT: begin
                if (out_if.out_ready) begin
                    if (pos_last_s) begin
                        next_state_s = ST_FIN;
                    end else begin
                        next_state_s = ST_LOAD;
                        pos_adv_s    = 1'b1;
                    end
                end else begin
                    next_state_s = ST_EMIT;
                end
            end
            ST_FIN: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Latency counter: zeroed in LOAD, counts unit cycles while in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_LOAD) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Control outputs decoded from the next state so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            unit_reset_r <= 1'b1;
            out_valid_r  <= 1'b0;
        end else begin
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (next_state_s == ST_FIN);
            unit_reset_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_LOAD) ||
                            (next_state_s == ST_FIN);
            out_valid_r  <= (next_state_s == ST_EMIT);
        end
    end

    // Result register: captures the unit output and its window tag once per window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r <= {DATA_WIDTH{1'b0}};
            out_row_r  <= {RW{1'b0}};
            out_col_r  <= {CW{1'b0}};
        end else if (capture_s) begin
            out_data_r <= unit_result;
            out_row_r  <= win_row;
            out_col_r  <= win_col;
        end else begin
            out_data_r <= out_data_r;
            out_row_r  <= out_row_r;
            out_col_r  <= out_col_r;
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign unit_reset       = unit_reset_r;
    assign out_if.out_valid = out_valid_r;
    assign out_if.out_data  = out_data_r;
    assign out_if.out_row   = out_row_r;
    assign out_if.out_col   = out_col_r;
endmodule

// File: tb/tb_conv_unit_scheduler.sv
// Directed bench for conv_unit_scheduler: a 4x4/F=3 instance and a 3x3/F=3
// instance, each driving a behavioural unit stub that returns a position
// code exactly LATENCY cycles after its reset is released.
module tb_conv_unit_scheduler;
    localparam int LAT = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b;
    logic        busy_a, done_a, unit_reset_a;
    logic        busy_b, done_b, unit_reset_b;
    logic [1:0]  win_row_a, win_col_a, win_row_b, win_col_b;
    logic [31:0] unit_result_a, unit_result_b;

    conv_unit_scheduler_if #(.DATA_WIDTH(32), .RW(2), .CW(2)) if_a ();
    conv_unit_scheduler_if #(.DATA_WIDTH(32), .RW(2), .CW(2)) if_b ();

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] enc(input logic [1:0] r, input logic [1:0] c);
        return 32'hA500_0000 | {22'd0, r, 8'd0} | {30'd0, c};
    endfunction

    conv_unit_scheduler #(.DATA_WIDTH(32), .D(2), .F(3), .H(4), .W(4), .LATENCY(LAT),
                          .RW(2), .CW(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .win_row(win_row_a), .win_col(win_col_a), .unit_reset(unit_reset_a),
        .unit_result(unit_result_a), .out_if(if_a)
    );

    conv_unit_scheduler #(.DATA_WIDTH(32), .D(2), .F(3), .H(3), .W(3), .LATENCY(LAT),
                          .RW(2), .CW(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .win_row(win_row_b), .win_col(win_col_b), .unit_reset(unit_reset_b),
        .unit_result(unit_result_b), .out_if(if_b)
    );

    // Unit stubs: latch the window while held in reset, count cycles after release.
    int         ucnt_a = 0, ucnt_b = 0;
    logic [1:0] lrow_a = 2'd0, lcol_a = 2'd0, lrow_b = 2'd0, lcol_b = 2'd0;
    always @(posedge clk) begin
        if (unit_reset_a) begin
            ucnt_a <= 0; lrow_a <= win_row_a; lcol_a <= win_col_a;
        end else begin
            ucnt_a <= ucnt_a + 1;
        end
        if (unit_reset_b) begin
            ucnt_b <= 0; lrow_b <= win_row_b; lcol_b <= win_col_b;
        end else begin
            ucnt_b <= ucnt_b + 1;
        end
    end
    assign unit_result_a = (ucnt_a == LAT - 1) ? enc(lrow_a, lcol_a) : 32'hDEAD_BEEF;
    assign unit_result_b = (ucnt_b == LAT - 1) ? enc(lrow_b, lcol_b) : 32'hDEAD_BEEF;

    // Observations collected by run_image (instance A).
    int          hs_cnt, done_cnt, done_cyc, ur_cnt;
    int          hs_cyc [8];
    logic [1:0]  hs_row [8], hs_col [8], ur_row [8], ur_col [8];
    logic [31:0] hs_data [8];
    logic        busy_after;

    // Pulse start on instance A and record handshakes, done and LOAD windows for max_cyc cycles.
    // Cycle 1 is the first cycle after the start edge; extra start pulses land in cycles sp0..sp2.
    task automatic run_image(input int max_cyc, input int sp0, input int sp1, input int sp2);
        hs_cnt = 0; done_cnt = 0; done_cyc = -10; ur_cnt = 0; busy_after = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int n = 1; n <= max_cyc; n++) begin
            if (if_a.out_valid && if_a.out_ready) begin
                if (hs_cnt < 8) begin
                    hs_cyc[hs_cnt] = n; hs_row[hs_cnt] = if_a.out_row;
                    hs_col[hs_cnt] = if_a.out_col; hs_data[hs_cnt] = if_a.out_data;
                end
                hs_cnt++;
            end
            if (busy_a && !done_a && unit_reset_a) begin
                if (ur_cnt < 8) begin
                    ur_row[ur_cnt] = win_row_a; ur_col[ur_cnt] = win_col_a;
                end
                ur_cnt++;
            end
            if (done_cnt > 0 && n == done_cyc + 1) busy_after = busy_a;
            if (done_a) begin
                done_cnt++; done_cyc = n;
            end
            start_a = (n == sp0) || (n == sp1) || (n == sp2);
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, unit_reset_a, if_a.out_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL reset_ctrl busy/done/unit_reset/valid=%b expected 0010",
                     {busy_a, done_a, unit_reset_a, if_a.out_valid});
        end
        checks++;
        if ({win_row_a, win_col_a, if_a.out_row, if_a.out_col, if_a.out_data} !== 40'd0) begin
            failures++;
            $display("FAIL reset_data win=%0d,%0d tag=%0d,%0d data=%h expected all zero",
                     win_row_a, win_col_a, if_a.out_row, if_a.out_col, if_a.out_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, unit_reset_a, if_a.out_valid} !== 3'b010) begin
            failures++;
            $display("FAIL idle_after_reset busy/unit_reset/valid=%b expected 010",
                     {busy_a, unit_reset_a, if_a.out_valid});
        end
    endtask

    task automatic test_full_image();
        run_image(120, 0, 0, 0);
        checks++;
        if (hs_cnt !== 4) begin
            failures++; $display("FAIL full_hs_count got %0d expected 4", hs_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            logic [1:0] er, ec;
            er = 2'(i / 2); ec = 2'(i % 2);
            checks++;
            if (hs_row[i] !== er || hs_col[i] !== ec || hs_data[i] !== enc(er, ec)) begin
                failures++;
                $display("FAIL full_out%0d got (%0d,%0d) %h expected (%0d,%0d) %h", i,
                         hs_row[i], hs_col[i], hs_data[i], er, ec, enc(er, ec));
            end
            checks++;
            if (hs_cyc[i] !== 22 * (i + 1)) begin
                failures++;
                $display("FAIL full_timing%0d got cycle %0d expected %0d", i, hs_cyc[i], 22 * (i + 1));
            end
            checks++;
            if (ur_row[i] !== er || ur_col[i] !== ec) begin
                failures++;
                $display("FAIL load_win%0d got (%0d,%0d) expected (%0d,%0d)", i,
                         ur_row[i], ur_col[i], er, ec);
            end
        end
        checks++;
        if (ur_cnt !== 4) begin
            failures++; $display("FAIL unit_reset_pulses got %0d expected 4", ur_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 89) begin
            failures++;
            $display("FAIL full_done count=%0d cycle=%0d expected 1 at 89", done_cnt, done_cyc);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            failures++; $display("FAIL busy_after_done got %b expected 0", busy_after);
        end
    endtask

    task automatic test_start_ignored();
        run_image(130, 5, 22, 89);
        checks++;
        if (hs_cnt !== 4 || done_cnt !== 1 || done_cyc !== 89) begin
            failures++;
            $display("FAIL start_ignored hs=%0d done=%0d at %0d expected 4,1 at 89",
                     hs_cnt, done_cnt, done_cyc);
        end
        checks++;
        if (busy_a !== 1'b0 || unit_reset_a !== 1'b1) begin
            failures++;
            $display("FAIL start_ignored_idle busy=%b unit_reset=%b expected 0,1", busy_a, unit_reset_a);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d0;
        logic [1:0]  r0, c0;
        int          waited;
        bit          seen;
        if_a.out_ready = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        waited = 0;
        while (!if_a.out_valid && waited < 100) begin
            @(negedge clk); waited++;
        end
        checks++;
        if (if_a.out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_first_valid got %b expected 1", if_a.out_valid);
        end
        d0 = if_a.out_data; r0 = if_a.out_row; c0 = if_a.out_col;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (if_a.out_valid !== 1'b1 || unit_reset_a !== 1'b0 || if_a.out_data !== enc(2'd0, 2'd0) ||
                if_a.out_data !== d0 || if_a.out_row !== r0 || if_a.out_col !== c0) begin
                failures++;
                $display("FAIL stall_hold%0d valid=%b unit_reset=%b data=%h tag=%0d,%0d expected 1,0,%h,0,0",
                         k, if_a.out_valid, unit_reset_a, if_a.out_data, if_a.out_row, if_a.out_col,
                         enc(2'd0, 2'd0));
            end
        end
        if_a.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (if_a.out_valid !== 1'b0 || unit_reset_a !== 1'b1 || win_row_a !== 2'd0 || win_col_a !== 2'd1) begin
            failures++;
            $display("FAIL stall_release valid=%b unit_reset=%b win=%0d,%0d expected 0,1,0,1",
                     if_a.out_valid, unit_reset_a, win_row_a, win_col_a);
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL stall_done got none expected done within 200 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (33) @(negedge clk);
        checks++;
        if (win_row_a !== 2'd0 || win_col_a !== 2'd1 || unit_reset_a !== 1'b0 || if_a.out_data !== enc(2'd0, 2'd0)) begin
            failures++;
            $display("FAIL abort_pre win=%0d,%0d unit_reset=%b data=%h expected 0,1,0,%h",
                     win_row_a, win_col_a, unit_reset_a, if_a.out_data, enc(2'd0, 2'd0));
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy_a, done_a, unit_reset_a, if_a.out_valid} !== 4'b0010 ||
            {win_row_a, win_col_a, if_a.out_row, if_a.out_col, if_a.out_data} !== 40'd0) begin
            failures++;
            $display("FAIL abort_async ctrl=%b win=%0d,%0d tag=%0d,%0d data=%h expected 0010 and zeros",
                     {busy_a, done_a, unit_reset_a, if_a.out_valid}, win_row_a, win_col_a,
                     if_a.out_row, if_a.out_col, if_a.out_data);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        run_image(30, 0, 0, 0);
        checks++;
        if (hs_cnt !== 1 || hs_cyc[0] !== 22 || hs_row[0] !== 2'd0 || hs_col[0] !== 2'd0 ||
            hs_data[0] !== enc(2'd0, 2'd0)) begin
            failures++;
            $display("FAIL abort_restart hs=%0d cycle=%0d tag=%0d,%0d data=%h expected 1 at 22 (0,0) %h",
                     hs_cnt, hs_cyc[0], hs_row[0], hs_col[0], hs_data[0], enc(2'd0, 2'd0));
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_window();
        int n_hs, hs_at, n_done, done_at;
        logic [31:0] d;
        logic [1:0]  r, c;
        n_hs = 0; hs_at = -1; n_done = 0; done_at = -1; d = 32'd0; r = 2'd3; c = 2'd3;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (if_b.out_valid && if_b.out_ready) begin
                n_hs++; hs_at = n; d = if_b.out_data; r = if_b.out_row; c = if_b.out_col;
            end
            if (done_b) begin
                n_done++; done_at = n;
            end
            @(negedge clk);
        end
        checks++;
        if (n_hs !== 1 || hs_at !== 22 || r !== 2'd0 || c !== 2'd0 || d !== enc(2'd0, 2'd0)) begin
            failures++;
            $display("FAIL single_out hs=%0d at %0d tag=%0d,%0d data=%h expected 1 at 22 (0,0) %h",
                     n_hs, hs_at, r, c, d, enc(2'd0, 2'd0));
        end
        checks++;
        if (n_done !== 1 || done_at !== 23) begin
            failures++; $display("FAIL single_done count=%0d at %0d expected 1 at 23", n_done, done_at);
        end
        checks++;
        if (busy_b !== 1'b0 || unit_reset_b !== 1'b1) begin
            failures++;
            $display("FAIL single_idle busy=%b unit_reset=%b expected 0,1", busy_b, unit_reset_b);
        end
    endtask

    initial begin
        test_reset();
        test_full_image();
        test_start_ignored();
        test_stall();
        test_abort();
        test_single_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
